// File: rtl/ahb3lite_pkg.sv
// Shared types and constants for the AHB3-Lite SRAM slave.
// Holds the bus encodings (HTRANS, HSIZE, HRESP), the slave state
// encoding and the default address/data widths used by the slave.

package ahb3lite_pkg;

    localparam int DEFAULT_HADDR_SIZE = 32;
    localparam int DEFAULT_HDATA_SIZE = 32;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_t;

endpackage

// File: rtl/ahb3lite_byte_strobe.sv
// Byte-lane strobe decoder for a 32-bit AHB data bus.
// Turns HSIZE and the two low address bits into a 4-bit lane mask and
// flags accesses whose address is not aligned to their size. Sizes above
// a word decode as a full word.

module ahb3lite_byte_strobe
    import ahb3lite_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addrLow,
    output logic [3:0] strobe,
    output logic       misaligned
);

    // Lane mask follows the low address bits; alignment is judged per size.
    always_comb begin
        strobe     = 4'b1111;
        misaligned = 1'b0;
        case (hsize)
            HSIZE_BYTE: begin
                strobe = 4'b0001 << addrLow;
            end
            HSIZE_HALF: begin
                strobe     = addrLow[1] ? 4'b1100 : 4'b0011;
                misaligned = addrLow[0];
            end
            HSIZE_WORD: begin
                misaligned = (addrLow != 2'b00);
            end
            default: begin
                strobe = 4'b1111;
            end
        endcase
    end

endmodule

// File: rtl/ahb3lite_sram_slave.sv
// AHB3-Lite SRAM-backed slave with pipelined address/data phases,
// byte/halfword/word accesses and WAIT_STATES wait cycles per data phase.
// Optional macro AHB3LITE_SLV_ERR_EN enables the two-cycle ERROR response
// for misaligned, oversized or out-of-range accesses; without it HRESP is
// always OKAY and high address bits alias onto the memory.

module ahb3lite_sram_slave
    import ahb3lite_pkg::*;
#(
    parameter int HADDR_SIZE  = DEFAULT_HADDR_SIZE,
    parameter int HDATA_SIZE  = DEFAULT_HDATA_SIZE,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int         IDX_BITS  = $clog2(MEM_DEPTH);
    localparam int         IDX_MSB   = IDX_BITS + 1;
    localparam logic [2:0] WAIT_LAST = 3'(WAIT_STATES);

    state_t              state;
    state_t              stateNext;
    state_t              acceptState;
    logic [2:0]          waitCnt;
    logic [2:0]          waitCntNext;
    logic [IDX_BITS-1:0] addrIndex;
    logic                addrWrite;
    logic [3:0]          addrStrobe;
    logic [3:0]          strobe;
    logic                misaligned;
    logic                accept;
    logic                acceptError;
    logic                takeAccept;
    logic                dataReady;
    logic                memWrite;
    logic                unusedInputs;

    logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

    ahb3lite_byte_strobe u_strobe (
        .hsize      (HSIZE),
        .addrLow    (HADDR[1:0]),
        .strobe     (strobe),
        .misaligned (misaligned)
    );

    assign accept    = HSEL & HREADY & HTRANS[1];
    assign dataReady = (waitCnt == WAIT_LAST);

`ifdef AHB3LITE_SLV_ERR_EN
    assign acceptError = misaligned | (HSIZE > 3'd2) | (|HADDR[HADDR_SIZE-1:IDX_MSB+1]);
`else
    assign acceptError = 1'b0;
`endif

    assign acceptState  = acceptError ? ST_ERR1 : ST_DATA;
    assign unusedInputs = ^{HBURST, HPROT, HTRANS[0], HADDR, HSIZE, misaligned};

    // Next state and wait counter; a new accept is only taken in cycles where
    // this slave is ready, so an in-flight beat is never overwritten.
    always_comb begin
        stateNext   = state;
        waitCntNext = waitCnt;
        takeAccept  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    takeAccept  = 1'b1;
                    stateNext   = acceptState;
                    waitCntNext = 3'd0;
                end
            end
            ST_DATA: begin
                if (dataReady) begin
                    waitCntNext = 3'd0;
                    if (accept) begin
                        takeAccept = 1'b1;
                        stateNext  = acceptState;
                    end else begin
                        stateNext = ST_IDLE;
                    end
                end else begin
                    waitCntNext = waitCnt + 3'd1;
                end
            end
            ST_ERR1: begin
                stateNext = ST_ERR2;
            end
            ST_ERR2: begin
                waitCntNext = 3'd0;
                if (accept) begin
                    takeAccept = 1'b1;
                    stateNext  = acceptState;
                end else begin
                    stateNext = ST_IDLE;
                end
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase
    end

    // Bus outputs decoded from the current state; read data is only driven
    // during a read data phase and is zero everywhere else.
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        HRDATA    = '0;
        memWrite  = 1'b0;
        case (state)
            ST_DATA: begin
                HREADYOUT = dataReady;
                memWrite  = dataReady & addrWrite & ~HRESET;
                if (!addrWrite) begin
                    HRDATA = mem[addrIndex];
                end
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
`ifdef AHB3LITE_SLV_ERR_EN
                HRESP     = HRESP_ERROR;
`endif
            end
            ST_ERR2: begin
                HREADYOUT = 1'b1;
`ifdef AHB3LITE_SLV_ERR_EN
                HRESP     = HRESP_ERROR;
`endif
            end
            default: begin
                HREADYOUT = 1'b1;
            end
        endcase
    end

    // State register plus the address-phase capture for the accepted beat.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state      <= ST_IDLE;
            waitCnt    <= 3'd0;
            addrIndex  <= '0;
            addrWrite  <= 1'b0;
            addrStrobe <= 4'b0000;
        end else begin
            state   <= stateNext;
            waitCnt <= waitCntNext;
            if (takeAccept) begin
                addrIndex  <= HADDR[IDX_MSB:2];
                addrWrite  <= HWRITE;
                addrStrobe <= strobe;
            end
        end
    end

    // Memory array is not reset; lanes commit at the edge that ends the write.
    always_ff @(posedge HCLK) begin
        if (memWrite) begin
            for (int i = 0; i < 4; i++) begin
                if (addrStrobe[i]) begin
                    mem[addrIndex][8*i +: 8] <= HWDATA[8*i +: 8];
                end
            end
        end
    end

endmodule
